// File: rtl/serial_deser_rx.sv
// Serial-to-parallel receiver: assembles WIDTH serial bits into a word and
// hands it off through a valid/ready output register with sticky overrun.
module serial_deser_rx #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_din,
    input  logic             s_valid,
    input  logic             s_start,
    input  logic             dir,
    input  logic             p_ready,
    input  logic             ovr_clr,
    output logic [WIDTH-1:0] p_dout,
    output logic             p_valid,
    output logic             busy,
    output logic             overrun
);

    localparam int unsigned CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } state_t;

    state_t           state, state_nx;
    logic [CW-1:0]    count, count_nx;
    logic [WIDTH-1:0] sr, sr_nx;
    logic             dir_q, dir_nx;
    logic             shift_dir_c;
    logic             word_done_c;
    logic             load_c;
    logic             drop_c;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Next-state, bit counter and shift path; a start bit or an idle bit opens a new word.
    always_comb begin
        state_nx    = state;
        count_nx    = count;
        sr_nx       = sr;
        dir_nx      = dir_q;
        shift_dir_c = dir_q;
        word_done_c = 1'b0;
        if (s_valid) begin
            if (state == IDLE || s_start) begin
                dir_nx      = dir;
                shift_dir_c = dir;
                count_nx    = CW'(1);
                state_nx    = COLLECT;
            end else if (count == LAST) begin
                word_done_c = 1'b1;
                count_nx    = '0;
                state_nx    = IDLE;
            end else begin
                count_nx    = count + CW'(1);
            end
            sr_nx = shift_dir_c ? {s_din, sr[WIDTH-1:1]} : {sr[WIDTH-2:0], s_din};
        end
    end

    assign load_c = word_done_c & (~p_valid | p_ready);
    assign drop_c = word_done_c & p_valid & ~p_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count   <= '0;
            sr      <= '0;
            dir_q   <= 1'b0;
            p_dout  <= '0;
            p_valid <= 1'b0;
            overrun <= 1'b0;
        end else begin
            count   <= count_nx;
            sr      <= sr_nx;
            dir_q   <= dir_nx;
            if (load_c) p_dout <= sr_nx;
            p_valid <= load_c | (p_valid & ~p_ready);
            // A drop on the same edge as a clear keeps the flag set.
            overrun <= drop_c | (overrun & ~ovr_clr);
        end
    end

    assign busy = (state == COLLECT);

endmodule

// File: tb/tb_serial_deser_rx.sv
// Directed, table-driven bench for serial_deser_rx at WIDTH=4, plus
// hand-written sequences for asynchronous reset.
module tb_serial_deser_rx;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       s_din = 1'b0, s_valid = 1'b0, s_start = 1'b0, dir = 1'b0;
    logic       p_ready = 1'b0, ovr_clr = 1'b0;
    logic [3:0] p_dout;
    logic       p_valid, busy, overrun;

    int checks   = 0;
    int failures = 0;

    serial_deser_rx #(.WIDTH(4)) dut (
        .clk    (clk),
        .rst    (rst),
        .s_din  (s_din),
        .s_valid(s_valid),
        .s_start(s_start),
        .dir    (dir),
        .p_ready(p_ready),
        .ovr_clr(ovr_clr),
        .p_dout (p_dout),
        .p_valid(p_valid),
        .busy   (busy),
        .overrun(overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       v, st, d, dr, rdy, clr;
        logic [3:0] e_dout;
        logic       e_pv, e_busy, e_ovr;
        string      nm;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(logic v, logic st, logic d, logic dr, logic rdy, logic clr,
                                logic [3:0] ed, logic epv, logic eb, logic eo, string nm);
        vec_t r;
        r.v = v; r.st = st; r.d = d; r.dr = dr; r.rdy = rdy; r.clr = clr;
        r.e_dout = ed; r.e_pv = epv; r.e_busy = eb; r.e_ovr = eo; r.nm = nm;
        return r;
    endfunction

    task automatic check(string nm, logic [3:0] ed, logic epv, logic eb, logic eo);
        logic [6:0] act, exp_v;
        act   = {p_dout, p_valid, busy, overrun};
        exp_v = {ed, epv, eb, eo};
        checks++;
        if (act !== exp_v) begin
            failures++;
            $display("FAIL %s: got dout=%b pv=%b busy=%b ovr=%b, want dout=%b pv=%b busy=%b ovr=%b",
                     nm, p_dout, p_valid, busy, overrun, ed, epv, eb, eo);
        end
    endtask

    task automatic drive(logic v, logic st, logic d, logic dr, logic rdy, logic clr);
        @(negedge clk);
        s_valid = v; s_start = st; s_din = d; dir = dr; p_ready = rdy; ovr_clr = clr;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        #1 rst = 1'b1;
        #1 check("reset", 4'b0000, 0, 0, 0);
        @(negedge clk) rst = 1'b0;

        // dir=0, bits 1101, ready held high
        vq.push_back(mk(1,1,1,0,1,0, 4'b0000,0,1,0, "msb_b0"));
        vq.push_back(mk(1,0,1,0,1,0, 4'b0000,0,1,0, "msb_b1"));
        vq.push_back(mk(1,0,0,0,1,0, 4'b0000,0,1,0, "msb_b2"));
        vq.push_back(mk(1,0,1,0,1,0, 4'b1101,1,0,0, "msb_done"));
        vq.push_back(mk(0,0,0,0,1,0, 4'b1101,0,0,0, "msb_consumed"));
        // dir=1, bits 1,0,1,1 with 2-cycle gaps, dir flipped to 0 mid-word
        vq.push_back(mk(1,1,1,1,1,0, 4'b1101,0,1,0, "lsb_b0"));
        vq.push_back(mk(0,0,0,0,1,0, 4'b1101,0,1,0, "lsb_gap0a"));
        vq.push_back(mk(0,0,0,0,1,0, 4'b1101,0,1,0, "lsb_gap0b"));
        vq.push_back(mk(1,0,0,0,1,0, 4'b1101,0,1,0, "lsb_b1"));
        vq.push_back(mk(0,0,0,0,1,0, 4'b1101,0,1,0, "lsb_gap1a"));
        vq.push_back(mk(0,0,0,0,1,0, 4'b1101,0,1,0, "lsb_gap1b"));
        vq.push_back(mk(1,0,1,0,1,0, 4'b1101,0,1,0, "lsb_b2"));
        vq.push_back(mk(0,0,0,0,1,0, 4'b1101,0,1,0, "lsb_gap2a"));
        vq.push_back(mk(0,0,0,0,1,0, 4'b1101,0,1,0, "lsb_gap2b"));
        vq.push_back(mk(1,0,1,0,1,0, 4'b1101,1,0,0, "lsb_done"));
        vq.push_back(mk(0,0,0,0,1,0, 4'b1101,0,0,0, "lsb_consumed"));
        // 2 bits, then restart with 0110
        vq.push_back(mk(1,1,1,0,1,0, 4'b1101,0,1,0, "rst_b0"));
        vq.push_back(mk(1,0,0,0,1,0, 4'b1101,0,1,0, "rst_b1"));
        vq.push_back(mk(1,1,0,0,1,0, 4'b1101,0,1,0, "restart_b0"));
        vq.push_back(mk(1,0,1,0,1,0, 4'b1101,0,1,0, "restart_b1"));
        vq.push_back(mk(1,0,1,0,1,0, 4'b1101,0,1,0, "restart_b2"));
        vq.push_back(mk(1,0,0,0,1,0, 4'b0110,1,0,0, "restart_done"));
        vq.push_back(mk(0,0,0,0,1,0, 4'b0110,0,0,0, "restart_consumed"));
        // ready low: 1010 then 0101 dropped, then clear, then consume
        vq.push_back(mk(1,1,1,0,0,0, 4'b0110,0,1,0, "ovr_a0"));
        vq.push_back(mk(1,0,0,0,0,0, 4'b0110,0,1,0, "ovr_a1"));
        vq.push_back(mk(1,0,1,0,0,0, 4'b0110,0,1,0, "ovr_a2"));
        vq.push_back(mk(1,0,0,0,0,0, 4'b1010,1,0,0, "ovr_a_done"));
        vq.push_back(mk(1,1,0,0,0,0, 4'b1010,1,1,0, "ovr_b0"));
        vq.push_back(mk(1,0,1,0,0,0, 4'b1010,1,1,0, "ovr_b1"));
        vq.push_back(mk(1,0,0,0,0,0, 4'b1010,1,1,0, "ovr_b2"));
        vq.push_back(mk(1,0,1,0,0,0, 4'b1010,1,0,1, "ovr_b_drop"));
        vq.push_back(mk(0,0,0,0,0,1, 4'b1010,1,0,0, "ovr_clear"));
        vq.push_back(mk(0,0,0,0,1,0, 4'b1010,0,0,0, "ovr_consume"));
        // drop and clear on the same edge: set wins
        vq.push_back(mk(1,1,1,0,0,0, 4'b1010,0,1,0, "sw_a0"));
        vq.push_back(mk(1,0,1,0,0,0, 4'b1010,0,1,0, "sw_a1"));
        vq.push_back(mk(1,0,0,0,0,0, 4'b1010,0,1,0, "sw_a2"));
        vq.push_back(mk(1,0,0,0,0,0, 4'b1100,1,0,0, "sw_a_done"));
        vq.push_back(mk(1,1,0,0,0,0, 4'b1100,1,1,0, "sw_b0"));
        vq.push_back(mk(1,0,0,0,0,0, 4'b1100,1,1,0, "sw_b1"));
        vq.push_back(mk(1,0,1,0,0,0, 4'b1100,1,1,0, "sw_b2"));
        vq.push_back(mk(1,0,1,0,0,1, 4'b1100,1,0,1, "sw_drop_and_clr"));
        vq.push_back(mk(0,0,0,0,1,1, 4'b1100,0,0,0, "sw_consume_clr"));
        // continuous 1101 0011; second word lands on the consume edge
        vq.push_back(mk(1,1,1,0,1,0, 4'b1100,0,1,0, "b2b_a0"));
        vq.push_back(mk(1,0,1,0,1,0, 4'b1100,0,1,0, "b2b_a1"));
        vq.push_back(mk(1,0,0,0,1,0, 4'b1100,0,1,0, "b2b_a2"));
        vq.push_back(mk(1,0,1,0,1,0, 4'b1101,1,0,0, "b2b_a_done"));
        vq.push_back(mk(1,0,0,0,0,0, 4'b1101,1,1,0, "b2b_b0"));
        vq.push_back(mk(1,0,0,0,0,0, 4'b1101,1,1,0, "b2b_b1"));
        vq.push_back(mk(1,0,1,0,0,0, 4'b1101,1,1,0, "b2b_b2"));
        vq.push_back(mk(1,0,1,0,1,0, 4'b0011,1,0,0, "b2b_b_done"));
        vq.push_back(mk(0,0,0,0,1,0, 4'b0011,0,0,0, "b2b_consumed"));

        foreach (vq[i]) begin
            drive(vq[i].v, vq[i].st, vq[i].d, vq[i].dr, vq[i].rdy, vq[i].clr);
            check(vq[i].nm, vq[i].e_dout, vq[i].e_pv, vq[i].e_busy, vq[i].e_ovr);
        end

        // Build up non-zero outputs, then assert reset between edges mid-word.
        drive(1,1,1,0,0,0); drive(1,0,1,0,0,0); drive(1,0,1,0,0,0); drive(1,0,1,0,0,0);
        check("pre_rst_word", 4'b1111, 1, 0, 0);
        drive(1,1,0,0,0,0); drive(1,0,0,0,0,0); drive(1,0,0,0,0,0); drive(1,0,0,0,0,0);
        check("pre_rst_drop", 4'b1111, 1, 0, 1);
        drive(1,1,1,0,0,0); drive(1,0,0,0,0,0);
        check("pre_rst_partial", 4'b1111, 1, 1, 1);
        @(negedge clk);
        s_valid = 1'b1; s_start = 1'b0; s_din = 1'b1; p_ready = 1'b0;
        #2 rst = 1'b1;
        #1 check("async_rst_immediate", 4'b0000, 0, 0, 0);
        @(posedge clk);
        #1 check("rst_ignores_inputs", 4'b0000, 0, 0, 0);
        @(negedge clk) rst = 1'b0;
        s_valid = 1'b0;

        drive(1,0,1,0,1,0); drive(1,0,0,0,1,0); drive(1,0,0,0,1,0);
        check("post_rst_b2", 4'b0000, 0, 1, 0);
        drive(1,0,1,0,1,0);
        check("post_rst_done", 4'b1001, 1, 0, 0);
        drive(0,0,0,0,1,0);
        check("post_rst_consumed", 4'b1001, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
